// File: rtl/lane_pp_pkg.sv
// Shared defaults and FSM encoding for the lane ping-pong writer.
package lane_pp_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        SWAP = 2'd2
    } pp_state_t;

endpackage

// File: rtl/lane_bank_ram.sv
// One DEPTH x DW bank: synchronous write, registered read that holds when idle.
module lane_bank_ram #(
    parameter int DEPTH = 32,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are never cleared; only the read register sees reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/lane_pingpong_writer.sv
// Double-buffered lane store: producer fills the back bank, display reads the front.
// Optional macro LANE_PP_STATS_EN adds the miss_cnt port and its counter.
module lane_pingpong_writer
    import lane_pp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          frame_sync,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
`ifdef LANE_PP_STATS_EN
    output logic [7:0]    miss_cnt,
`endif
    output logic          front_bank
);

    pp_state_t     state, state_nxt;
    logic [AW-1:0] wr_addr, wr_addr_nxt;
    logic          front_nxt;
    logic          beat;
    logic          rd_sel;
    logic [DW-1:0] rdata0, rdata1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            wr_addr    <= '0;
            front_bank <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            front_bank <= front_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        front_nxt   = front_bank;
        wr_ready    = 1'b0;
        beat        = 1'b0;
        case (state)
            FILL: begin
                wr_ready = 1'b1;
                beat     = wr_valid;
                // frame_sync is ignored here: a partial bank is never shown.
                if (wr_valid) begin
                    wr_addr_nxt = wr_addr + 1'b1;
                    if (wr_addr == AW'(DEPTH - 1))
                        state_nxt = FULL;
                end
            end
            FULL: begin
                if (frame_sync)
                    state_nxt = SWAP;
            end
            SWAP: begin
                front_nxt   = ~front_bank;
                wr_addr_nxt = '0;
                state_nxt   = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // rd_sel remembers which bank answered the last read so rd_data holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_sel <= front_bank;
        end
    end

    lane_bank_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (beat & front_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en & ~front_bank),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    lane_bank_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (beat & ~front_bank),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en & front_bank),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rd_data = rd_sel ? rdata1 : rdata0;

`ifdef LANE_PP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            miss_cnt <= '0;
        else if (state == FILL && frame_sync && miss_cnt != 8'hFF)
            miss_cnt <= miss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_lane_pingpong_writer.sv
// Directed bench: read expectations go to a queue, a monitor pops on rd_valid.
module tb_lane_pingpong_writer;

    localparam int DEPTH = 32;
    localparam int DW    = 8;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          frame_sync;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          front_bank;
`ifdef LANE_PP_STATS_EN
    logic [7:0]    miss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    lane_pingpong_writer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_sync (frame_sync),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
`ifdef LANE_PP_STATS_EN
        .miss_cnt   (miss_cnt),
`endif
        .front_bank (front_bank)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle after the posedge, sample on the falling edge.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got %0h with no read outstanding", rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic fs);
        chk("wr_ready_fill", 32'(wr_ready), 32'd1);
        wr_valid   = 1'b1;
        wr_data    = d;
        frame_sync = fs;
        step();
        wr_valid   = 1'b0;
        frame_sync = 1'b0;
    endtask

    // Read issued now; expected value pushed before the DUT answers.
    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; frame_sync = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_front", 32'(front_bank), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef LANE_PP_STATS_EN
        chk("rst_miss", 32'(miss_cnt), 32'd0);
`endif

        // Fill back bank 1 with 0x00..0x1F
        for (int i = 0; i < DEPTH; i++) beat(8'(i), 1'b0);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        step(); step();
        chk("full_hold", 32'(wr_ready), 32'd0);
        chk("full_front", 32'(front_bank), 32'd0);

        // Swap: SWAP cycle keeps front, toggles at its end
        frame_sync = 1'b1; step(); frame_sync = 1'b0;
        chk("swap_wr_ready", 32'(wr_ready), 32'd0);
        chk("swap_front_old", 32'(front_bank), 32'd0);
        step();
        chk("swap1_front", 32'(front_bank), 32'd1);
        chk("fill_again_ready", 32'(wr_ready), 32'd1);
        rd(5'd5, 8'h05);
        step();

        // Fill bank 0: frame_sync after 10 beats is a miss, not a swap
        for (int i = 0; i < 10; i++) beat(8'h40 + 8'(i), 1'b0);
        frame_sync = 1'b1; step(); frame_sync = 1'b0;
        chk("miss_front", 32'(front_bank), 32'd1);
`ifdef LANE_PP_STATS_EN
        chk("miss_cnt1", 32'(miss_cnt), 32'd1);
`endif
        for (int i = 10; i < DEPTH - 1; i++) beat(8'h40 + 8'(i), 1'b0);
        // Final beat together with frame_sync: stored, FULL, no toggle
        beat(8'h5F, 1'b1);
        chk("last_fs_ready", 32'(wr_ready), 32'd0);
        chk("last_fs_front", 32'(front_bank), 32'd1);
`ifdef LANE_PP_STATS_EN
        chk("miss_cnt2", 32'(miss_cnt), 32'd2);
`endif
        step();
        chk("last_fs_front2", 32'(front_bank), 32'd1);

        // Next frame_sync swaps; read in SWAP cycle hits old bank 1
        frame_sync = 1'b1; step(); frame_sync = 1'b0;
        rd(5'd7, 8'h07);
        rd(5'd7, 8'h47);
        chk("swap2_front", 32'(front_bank), 32'd0);
        rd(5'd31, 8'h5F);
        step();

        // Reset mid-fill at wr_addr=17 with a read in flight
        for (int i = 0; i < 17; i++) beat(8'hC0 + 8'(i), 1'b0);
        reset = 1'b1;
        wr_valid = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
        step();
        reset = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
        chk("midrst_front", 32'(front_bank), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst_ready", 32'(wr_ready), 32'd1);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);

        // Refill from address 0 proves wr_addr was cleared
        for (int i = 0; i < DEPTH; i++) beat(8'h80 + 8'(i), 1'b0);
        frame_sync = 1'b1; step(); frame_sync = 1'b0;
        step();
        chk("swap3_front", 32'(front_bank), 32'd1);
        rd(5'd0, 8'h80);
        rd(5'd17, 8'h91);
        step();
        chk("rd_hold_valid", 32'(rd_valid), 32'd0);
        chk("rd_hold_data", 32'(rd_data), 32'h91);
        step(); step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
